alu_decode: RTL and testbench

- Registered ALU-control decoder for the RV32 datapath.
- Maps the main decoder's 3-bit ALUOP and the instruction's funct3 field onto a 3-bit ALU_Control code for the ALU.
- Sits between the main control unit and the ALU.
- Output is registered: one clock of latency, with a valid/illegal sideband.

---
 rtl/alu_decode.sv | 87 ++++++++
 tb/tb_alu_decode.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_decode.sv
// alu_decode: registered ALU-control decoder for the RV32 datapath.
// Combines the main decoder's operation class (ALUOP) with the instruction
// funct3 field into a 3-bit ALU_Control code. One clock of latency, with a
// registered valid strobe and an "illegal combination" flag.
//
// Handshake: in_valid qualifies ALUOP/funct3 in the cycle it is high. There is
// no back-pressure, so a request is accepted on every rising edge where
// in_valid=1. out_valid is in_valid delayed by exactly one clock. While
// out_valid=1, ALU_Control/illegal belong to the request accepted on the
// previous edge. While out_valid=0 they hold the last accepted result.
module alu_decode (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] ALUOP,
  input  logic [2:0] funct3,
  output logic [2:0] ALU_Control,
  output logic       out_valid,
  output logic       illegal
);

  // ALU_Control encoding.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOP operation classes. Everything else is unsupported.
  localparam logic [2:0] OP_MEM     = 3'b000;
  localparam logic [2:0] OP_BRANCH  = 3'b001;
  localparam logic [2:0] OP_SPECIAL = 3'b111;

  logic [2:0] dec_ctrl;
  logic       dec_illegal;

  // Pure decode: full case on both selectors, so every input pattern yields a
  // defined code (ADD) even for unsupported combinations.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_illegal = 1'b0;
    case (ALUOP)
      OP_MEM:    dec_ctrl = ALU_ADD;
      OP_BRANCH: dec_ctrl = ALU_SUB;
      OP_SPECIAL: begin
        case (funct3)
          3'b000:  dec_ctrl = ALU_ADD;
          3'b001:  dec_ctrl = ALU_SLL;
          3'b010:  dec_ctrl = ALU_SLT;
          3'b100:  dec_ctrl = ALU_XOR;
          3'b101:  dec_ctrl = ALU_SRL;
          3'b110:  dec_ctrl = ALU_OR;
          3'b111:  dec_ctrl = ALU_AND;
          default: begin
            // funct3=011 has no operation in this ALU.
            dec_ctrl    = ALU_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl    = ALU_ADD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Output register: results load only on a valid request, the strobe follows
  // in_valid every edge, and reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_Control <= ALU_ADD;
      illegal     <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ALU_Control <= dec_ctrl;
        illegal     <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_decode.sv
// tb_alu_decode: directed vectors with hand-computed results. The driver
// pushes the expected response for each cycle into exp_q. A monitor pops one
// entry per clock and compares it against the DUT outputs.
module tb_alu_decode;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] ALUOP;
  logic [2:0] funct3;
  logic [2:0] ALU_Control;
  logic       out_valid;
  logic       illegal;

  int tests_run = 0;
  int tests_failed = 0;
  bit mon_en = 1'b0;

  // Entry layout: {out_valid, ALU_Control[2:0], illegal}.
  logic [4:0] exp_q[$];

  alu_decode dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .ALUOP       (ALUOP),
    .funct3      (funct3),
    .ALU_Control (ALU_Control),
    .out_valid   (out_valid),
    .illegal     (illegal)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Driver: apply one request at the falling edge and record what the DUT
  // must show after the next rising edge.
  task automatic drive(input logic [2:0] op, input logic [2:0] f3, input logic v,
                       input logic [2:0] exp_ctrl, input logic exp_ill);
    ALUOP    = op;
    funct3   = f3;
    in_valid = v;
    exp_q.push_back({v, exp_ctrl, exp_ill});
    @(negedge clk);
  endtask

  // Monitor: one expected entry per rising edge while enabled.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_valid", {3'b000, out_valid}, {3'b000, e[4]});
          check("ALU_Control", {1'b0, ALU_Control}, {1'b0, e[3:1]});
          check("illegal", {3'b000, illegal}, {3'b000, e[0]});
        end else begin
          check("idle_out_valid", {3'b000, out_valid}, 4'h0);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    ALUOP    = 3'b111;
    funct3   = 3'b001;

    // Reset held with a live request on the inputs.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {1'b0, ALU_Control}, 4'h0);
    check("reset_valid", {3'b000, out_valid}, 4'h0);
    check("reset_illegal", {3'b000, illegal}, 4'h0);

    rst_n  = 1'b1;
    mon_en = 1'b1;

    // SPECIAL class, back-to-back every cycle.
    drive(3'b111, 3'b000, 1'b1, 3'b000, 1'b0);
    drive(3'b111, 3'b001, 1'b1, 3'b011, 1'b0);
    drive(3'b111, 3'b111, 1'b1, 3'b010, 1'b0);
    drive(3'b111, 3'b010, 1'b1, 3'b111, 1'b0);
    drive(3'b111, 3'b100, 1'b1, 3'b101, 1'b0);
    drive(3'b111, 3'b101, 1'b1, 3'b110, 1'b0);
    drive(3'b111, 3'b110, 1'b1, 3'b100, 1'b0);
    drive(3'b111, 3'b011, 1'b1, 3'b000, 1'b1);
    // Fixed classes ignore funct3.
    drive(3'b000, 3'b101, 1'b1, 3'b000, 1'b0);
    drive(3'b001, 3'b010, 1'b1, 3'b001, 1'b0);
    // Unsupported classes.
    drive(3'b010, 3'b101, 1'b1, 3'b000, 1'b1);
    drive(3'b011, 3'b101, 1'b1, 3'b000, 1'b1);
    drive(3'b100, 3'b101, 1'b1, 3'b000, 1'b1);
    drive(3'b101, 3'b101, 1'b1, 3'b000, 1'b1);
    drive(3'b110, 3'b101, 1'b1, 3'b000, 1'b1);
    // Hold: invalid requests must not disturb the last result.
    drive(3'b001, 3'b000, 1'b1, 3'b001, 1'b0);
    drive(3'b111, 3'b111, 1'b0, 3'b001, 1'b0);
    drive(3'b111, 3'b011, 1'b0, 3'b001, 1'b0);
    drive(3'b111, 3'b101, 1'b1, 3'b110, 1'b0);
    drive(3'b111, 3'b001, 1'b1, 3'b011, 1'b0);

    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", {1'b0, 3'(exp_q.size())}, 4'h0);

    // Asynchronous reset in the middle of a cycle, after a non-zero result.
    drive(3'b111, 3'b101, 1'b1, 3'b110, 1'b1 ^ 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_ctrl", {1'b0, ALU_Control}, 4'h0);
    check("async_valid", {3'b000, out_valid}, 4'h0);
    check("async_illegal", {3'b000, illegal}, 4'h0);
    @(posedge clk);
    #1;
    check("async_hold_valid", {3'b000, out_valid}, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
